// File: rtl/schedule_1_pkg.sv
// Shared definitions for scheduler stage 1: opcode constants, FSM encoding and the
// registered output bundle handed to stage 2.
package schedule_1_pkg;

   localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;
   localparam logic [6:0]  OP_FENCE   = 7'b0001111;
   localparam logic [16:0] NOP_OPCODE = 17'h0013;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StDrain = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [7:0]  lane;
      logic [31:0] pc;
      logic [16:0] opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] csr;
      logic [31:0] imm;
   } sched_out_t;

   function automatic sched_out_t bubble_out();
      sched_out_t b;
      b        = '0;
      b.opcode = NOP_OPCODE;
      return b;
   endfunction

   function automatic logic is_serial(input logic [6:0] op);
      return (op == OP_SYSTEM) || (op == OP_FENCE);
   endfunction

endpackage

// File: rtl/schedule_1_scoreboard.sv
// Pending-write mask; a writeback clears its bit combinationally so the hazard check
// sees the retirement in the same cycle.
module schedule_1_scoreboard (
   input  logic        CLK,
   input  logic        RST,
   input  logic        flush_i,
   input  logic        set_i,
   input  logic [4:0]  set_rd_i,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   output logic [31:0] eff_mask_o
);

   logic [31:0] pending_q, pending_d, wb_clr;

   always_comb begin
      wb_clr = '0;
      if (wb_valid_i) wb_clr[wb_rd_i] = 1'b1;
      eff_mask_o = pending_q & ~wb_clr;
      // Set is applied after the clear so a same-register set wins.
      pending_d  = eff_mask_o;
      if (set_i && (set_rd_i != 5'd0)) pending_d[set_rd_i] = 1'b1;
      if (flush_i) pending_d = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) pending_q <= '0;
      else     pending_q <= pending_d;
   end

endmodule

// File: rtl/schedule_1.sv
// Scheduler stage 1: lane select, register-hazard check, SYSTEM/FENCE serialisation and
// the registered hand-off to stage 2.
module schedule_1
   import schedule_1_pkg::*;
#(
   parameter int unsigned COP_NUMS = 32'd1,
   parameter int unsigned PNUMS    = COP_NUMS + 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                FLUSH,
   input  logic                MMU_WAIT,
   input  logic [PNUMS-1:0]    CHECK_ACCEPT,
   input  logic [32*PNUMS-1:0] CHECK_PC,
   input  logic [17*PNUMS-1:0] CHECK_OPCODE,
   input  logic [5*PNUMS-1:0]  CHECK_RD,
   input  logic [5*PNUMS-1:0]  CHECK_RS1,
   input  logic [5*PNUMS-1:0]  CHECK_RS2,
   input  logic [12*PNUMS-1:0] CHECK_CSR,
   input  logic [32*PNUMS-1:0] CHECK_IMM,
   input  logic                WB_VALID,
   input  logic [4:0]          WB_RD,
   output logic                SCHEDULE_STALL,
   output logic                SCHEDULE_VALID,
   output logic                SCHEDULE_ILLEGAL,
   output logic [7:0]          SCHEDULE_LANE,
   output logic [31:0]         SCHEDULE_PC,
   output logic [16:0]         SCHEDULE_OPCODE,
   output logic [4:0]          SCHEDULE_RD,
   output logic [4:0]          SCHEDULE_RS1,
   output logic [4:0]          SCHEDULE_RS2,
   output logic [11:0]         SCHEDULE_CSR,
   output logic [31:0]         SCHEDULE_IMM,
   output logic [31:0]         STALL_CNT
);

   int           sel_idx;
   logic         any_accept, hazard, serial, stall, issue, sb_set;
   logic [31:0]  eff_mask;
   sched_out_t   sel, out_q, out_d;
   sched_state_e state_q, state_d, state_n;
   logic [31:0]  cnt_q, cnt_d;

   // Lowest-index accepting lane; lane 0 when none accepts.
   always_comb begin
      sel_idx = 0;
      for (int i = int'(PNUMS) - 1; i >= 0; i--) begin
         if (CHECK_ACCEPT[i]) sel_idx = i;
      end
   end

   assign any_accept = |CHECK_ACCEPT;

   always_comb begin
      sel         = '0;
      sel.valid   = 1'b1;
      sel.illegal = ~any_accept;
      sel.lane    = sel_idx[7:0];
      sel.pc      = CHECK_PC[sel_idx*32 +: 32];
      sel.opcode  = CHECK_OPCODE[sel_idx*17 +: 17];
      sel.rd      = CHECK_RD[sel_idx*5 +: 5];
      sel.rs1     = CHECK_RS1[sel_idx*5 +: 5];
      sel.rs2     = CHECK_RS2[sel_idx*5 +: 5];
      sel.csr     = CHECK_CSR[sel_idx*12 +: 12];
      sel.imm     = CHECK_IMM[sel_idx*32 +: 32];
   end

   // Bit 0 of the mask is never set, so x0 operands cannot hazard.
   assign hazard = any_accept &&
                   (eff_mask[sel.rs1] || eff_mask[sel.rs2] || eff_mask[sel.rd]);
   assign serial = is_serial(sel.opcode[6:0]);

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         StRun: begin
            if (hazard) begin
               stall = 1'b1;
            end else if (serial && (|eff_mask)) begin
               stall   = 1'b1;
               state_d = StDrain;
            end else begin
               issue = 1'b1;
            end
         end
         StDrain: begin
            if (|eff_mask) begin
               stall = 1'b1;
            end else begin
               issue   = 1'b1;
               state_d = StRun;
            end
         end
      endcase
   end

   assign SCHEDULE_STALL = stall & ~MMU_WAIT;
   assign sb_set         = issue & any_accept & ~MMU_WAIT & ~FLUSH;

   always_comb begin
      out_d   = out_q;
      state_n = state_q;
      cnt_d   = cnt_q;
      if (FLUSH) begin
         out_d   = bubble_out();
         state_n = StRun;
      end else if (!MMU_WAIT) begin
         out_d   = issue ? sel : bubble_out();
         state_n = state_d;
         if (stall) cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_q   <= bubble_out();
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         out_q   <= out_d;
         state_q <= state_n;
         cnt_q   <= cnt_d;
      end
   end

   schedule_1_scoreboard u_scoreboard (
      .CLK        (CLK),
      .RST        (RST),
      .flush_i    (FLUSH),
      .set_i      (sb_set),
      .set_rd_i   (sel.rd),
      .wb_valid_i (WB_VALID),
      .wb_rd_i    (WB_RD),
      .eff_mask_o (eff_mask)
   );

   assign SCHEDULE_VALID   = out_q.valid;
   assign SCHEDULE_ILLEGAL = out_q.illegal;
   assign SCHEDULE_LANE    = out_q.lane;
   assign SCHEDULE_PC      = out_q.pc;
   assign SCHEDULE_OPCODE  = out_q.opcode;
   assign SCHEDULE_RD      = out_q.rd;
   assign SCHEDULE_RS1     = out_q.rs1;
   assign SCHEDULE_RS2     = out_q.rs2;
   assign SCHEDULE_CSR     = out_q.csr;
   assign SCHEDULE_IMM     = out_q.imm;
   assign STALL_CNT        = cnt_q;

endmodule
